// File: rtl/fifo_wr_sched_pkg.sv
// ============================================================================
// fifo_sched_pkg : shared types/helpers for the FIFO write scheduler | Rev 1.0
// ============================================================================
`default_nettype none

package fifo_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_FLUSH = 2'd2
  } sched_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 16;

  // Index width that never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_sched_if.sv
// ============================================================================
// fifo_wr_sched_if : requester/FIFO-side bundle of the write scheduler | Rev 1.0
// ============================================================================
`default_nettype none

interface fifo_wr_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          flush_req;
  logic                          flush_done;
  logic                          fifo_full;
  logic                          fifo_wr_enable;
  logic                          fifo_flush;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;
  logic                          busy;

  // Environment side: requesters plus the FIFO full flag.
  modport master (
    output req_valid, req_last, req_data, flush_req, fifo_full,
    input  req_ready, flush_done, fifo_wr_enable, fifo_flush, fifo_wr_data,
           grant_id, busy
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_last, req_data, flush_req, fifo_full,
    output req_ready, flush_done, fifo_wr_enable, fifo_flush, fifo_wr_data,
           grant_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/fifo_wr_sched_rr_pick.sv
// ============================================================================
// rr_pick : first set bit of a vector at or after a cyclic pointer | Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int w_idx;
    found = 1'b0;
    index = '0;
    w_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[w_idx]) begin
        found = 1'b1;
        index = ID_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_sched.sv
// ============================================================================
// fifo_wr_sched : round-robin burst scheduler for the async FIFO write port | Rev 1.0
// ============================================================================
`default_nettype none

module fifo_wr_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic              w_clk,
  input  logic              wresetn,
  fifo_wr_sched_if.slave    bus
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = id_width(MAX_BURST);

  sched_state_e          r_state, w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr, w_rr_nxt;
  logic [ID_W-1:0]       r_owner, w_owner_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_cnt_nxt;
  logic                  r_flush_pend, w_pend_nxt;

  logic                  w_found;
  logic [ID_W-1:0]       w_pick;
  logic                  w_accept;
  logic                  w_release;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_wr_enable;
  logic                  w_flush;
  logic [DATA_WIDTH-1:0] w_wr_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .valid (bus.req_valid),
    .ptr   (r_rr_ptr),
    .found (w_found),
    .index (w_pick)
  );

  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_beat_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_owner      <= w_owner_nxt;
      r_beat_cnt   <= w_cnt_nxt;
      r_flush_pend <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_beat_cnt;
    w_pend_nxt  = r_flush_pend;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_wr_enable = 1'b0;
    w_flush     = 1'b0;
    w_wr_data   = '0;

    case (r_state)
      S_IDLE: begin
        if (r_flush_pend || bus.flush_req) begin
          w_state_nxt = S_FLUSH;
        end else if (w_found) begin
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BURST;
        end
      end

      S_BURST: begin
        w_ready[r_owner] = !bus.fifo_full;
        w_accept         = bus.req_valid[r_owner] && !bus.fifo_full;
        if (bus.flush_req) begin
          w_pend_nxt = 1'b1;
        end
        if (w_accept) begin
          w_wr_enable = 1'b1;
          w_wr_data   = bus.req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
          w_cnt_nxt   = r_beat_cnt + CNT_W'(1);
          w_release   = bus.req_last[r_owner] ||
                        (r_beat_cnt == CNT_W'(MAX_BURST - 1));
        end
        // A flush seen on the release beat goes straight to FLUSH, no bubble.
        if (w_release) begin
          w_rr_nxt    = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);
          w_cnt_nxt   = '0;
          w_state_nxt = (r_flush_pend || bus.flush_req) ? S_FLUSH : S_IDLE;
        end
      end

      S_FLUSH: begin
        // The FIFO only clears its pointer when enable and flush coincide.
        w_wr_enable = 1'b1;
        w_flush     = 1'b1;
        w_pend_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready      = w_ready;
  assign bus.fifo_wr_enable = w_wr_enable;
  assign bus.fifo_flush     = w_flush;
  assign bus.flush_done     = w_flush;
  assign bus.fifo_wr_data   = w_wr_data;
  assign bus.grant_id       = r_owner;
  assign bus.busy           = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/fifo_wr_sched.md
Name: fifo_wr_sched

Overview:
- Write-side scheduler for the async FIFO, in the w_clk domain.
- Shares the single FIFO write port among NUM_REQ requesters using round-robin arbitration with burst locking.
- Enforces a maximum burst length.
- Sequences the flush operation so the write-pointer clear happens only at a burst boundary.
- Drives the FIFO write-side enable/flush inputs and observes its registered full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, data word width.
- MAX_BURST, 16, maximum beats per grant before forced release (power of 2, ≥2).

Ports:
- w_clk  in  1  write-domain clock
- wresetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_last  in  NUM_REQ  per-requester last beat of burst
- req_data  in  NUM_REQ*DATA_WIDTH  packed per-requester data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept
- flush_req  in  1  level request to flush the FIFO
- flush_done  out  1  one-cycle pulse when the flush is issued
- fifo_full  in  1  registered full flag from the FIFO write side
- fifo_wr_enable  out  1  FIFO write-side enable
- fifo_flush  out  1  FIFO flush
- fifo_wr_data  out  DATA_WIDTH  write data to FIFO memory
- grant_id  out  $clog2(NUM_REQ)  current owner
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, wresetn=0):
  - State = IDLE; rr_ptr = 0; owner = 0; beat_cnt = 0; flush_pend = 0.
  - All outputs 0.
- States: IDLE, BURST, FLUSH.
- IDLE:
  - If flush_pend or flush_req: go to FLUSH next cycle.
  - Else, if any req_valid: the first valid index at or after rr_ptr (cyclic) is registered as owner; go to BURST; beat_cnt = 0.
  - No grant is issued in IDLE; req_ready = 0.
- BURST:
  - req_ready[owner] = !fifo_full (combinational); other ready bits = 0.
  - A beat is accepted when req_valid[owner] && req_ready[owner].
  - On an accepted beat: fifo_wr_enable = 1 and fifo_wr_data = req_data[owner] in the same cycle; beat_cnt increments.
  - Release occurs on the accepted beat where req_last[owner]=1 or beat_cnt == MAX_BURST-1.
  - On release: rr_ptr = owner+1 (mod NUM_REQ, wrap NUM_REQ-1 → 0); next state = FLUSH if flush_pend or flush_req, else IDLE.
  - The owner may drop valid mid-burst; the grant is held (no timeout).
  - fifo_full=1 stalls the burst; beat_cnt is unchanged.
- flush_req arriving in BURST sets flush_pend. No new grant is issued until the flush completes.
- FLUSH (exactly 1 cycle):
  - fifo_flush = 1 and fifo_wr_enable = 1. Both are required: the FIFO clears its pointer only when enable and flush are both high.
  - flush_done = 1; flush_pend cleared; rr_ptr unchanged; next state IDLE.
  - All req_ready = 0.
  - fifo_flush is issued even when fifo_full=1.
  - If flush_req is still high in the following IDLE cycle, another flush is issued. Requesters must drop flush_req on flush_done.
- Latency:
  - req_valid rising in IDLE at cycle N → earliest accepted beat at cycle N+1.
  - One idle bubble follows every release.
- Outputs:
  - fifo_wr_data = 0 when no beat is accepted.
  - grant_id = owner (registered).
  - fifo_wr_enable is never asserted in IDLE.
- Reset mid-burst: immediate return to IDLE. No partial state is retained, including flush_pend.
- Simultaneous release beat and flush_req: the beat is written, then FLUSH follows directly with no IDLE cycle.

Decomposition:
- Package fifo_sched_pkg:
  - sched_state_e enum (IDLE, BURST, FLUSH).
  - Localparam helpers for ID width.
- Sub-module rr_pick: combinational cyclic priority pick.
  - Inputs: valid vector, rr_ptr.
  - Outputs: found, index.
  - Instantiated once.

Test Plan:
- Req 0 only, 4-beat burst with last on beat 4, fifo_full=0 → grant_id=0; 4 consecutive fifo_wr_enable pulses starting 1 cycle after valid; busy drops after the last beat; rr_ptr=1.
- Reqs 0, 1, 3 all valid continuously, 2-beat bursts → grant order 0, 1, 3, 0; one idle cycle between bursts.
- MAX_BURST=16, req 2 streams 20 beats with no last → 16 writes, release, re-grant to req 2 (sole requester) after a 1-cycle bubble, then 4 more writes.
- fifo_full=1 for 3 cycles mid-burst → req_ready low, no fifo_wr_enable; the burst resumes with beat_cnt preserved.
- flush_req asserted on beat 2 of a 4-beat burst → beats 3 and 4 are written; the next cycle has fifo_flush=fifo_wr_enable=flush_done=1; then IDLE.
- wresetn pulsed low mid-burst → all outputs 0 asynchronously; after release the first grant goes to the lowest-index valid requester (rr_ptr=0).
